// File: rtl/counter_checker.sv
// Reference-model checker for a 16-bit up/down/load counter: one-cycle-latency compare of Q (and RCO
// when COUNTER_CHECKER_RCO_CHECK_EN is defined) with error/compare statistics.
module counter_checker (
  input  logic        CLK,
  input  logic        RESET_L,
  input  logic [15:0] D,
  input  logic        ENB,
  input  logic [1:0]  MODO,
  input  logic [15:0] Q,
  input  logic        RCO,
  input  logic        CLR,
  output logic        SYNCED,
  output logic [15:0] EXP_Q,
  output logic        ERR,
  output logic        ERR_STICKY,
  output logic [7:0]  ERR_CNT,
  output logic [15:0] CHK_CNT
);

  localparam int unsigned DW = 16;
  localparam int unsigned EW = 8;
  localparam int unsigned CW = 16;

  localparam logic [1:0] MODO_UP   = 2'b00;
  localparam logic [1:0] MODO_DN1  = 2'b01;
  localparam logic [1:0] MODO_DN3  = 2'b10;
  localparam logic [1:0] MODO_LOAD = 2'b11;

  typedef enum logic [1:0] {
    UNSYNC = 2'b00,
    ARMED  = 2'b01,
    CHECK  = 2'b10
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [DW-1:0] exp_nxt;
  logic          rco_nxt;
  logic          exp_rco;
  logic          load_c;
  logic          cmp_c;
  logic          mismatch_c;

  // Reference model: next expected value and expected ripple carry
  always_comb begin
    exp_nxt = EXP_Q;
    rco_nxt = 1'b0;
    load_c  = ENB && (MODO == MODO_LOAD);
    if (ENB) begin
      case (MODO)
        MODO_UP: begin
          exp_nxt = EXP_Q + DW'(1);
          rco_nxt = (EXP_Q == {DW{1'b1}});
        end
        MODO_DN1: begin
          exp_nxt = EXP_Q - DW'(1);
          rco_nxt = (EXP_Q == '0);
        end
        MODO_DN3: begin
          exp_nxt = EXP_Q - DW'(3);
          rco_nxt = (EXP_Q < DW'(3));
        end
        default: begin
          exp_nxt = D;
          rco_nxt = 1'b0;
        end
      endcase
    end
  end

  // Sync FSM next state; a load in ARMED keeps the checker in ARMED
  always_comb begin
    state_nxt = state;
    cmp_c     = 1'b0;
    case (state)
      UNSYNC: begin
        if (load_c) state_nxt = ARMED;
      end
      ARMED: begin
        cmp_c     = 1'b1;
        state_nxt = load_c ? ARMED : CHECK;
      end
      CHECK: begin
        cmp_c = 1'b1;
      end
      default: state_nxt = UNSYNC;
    endcase
    if (CLR) state_nxt = UNSYNC;
  end

`ifdef COUNTER_CHECKER_RCO_CHECK_EN
  assign mismatch_c = (Q != EXP_Q) || (RCO != exp_rco);
`else
  logic unused_rco_c;
  assign unused_rco_c = RCO ^ exp_rco;
  assign mismatch_c   = (Q != EXP_Q);
`endif

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) state <= UNSYNC;
    else          state <= state_nxt;
  end

  // Model register and statistics; CLR outranks any load, compare or mismatch
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      SYNCED     <= 1'b0;
      EXP_Q      <= '0;
      exp_rco    <= 1'b0;
      ERR        <= 1'b0;
      ERR_STICKY <= 1'b0;
      ERR_CNT    <= '0;
      CHK_CNT    <= '0;
    end else if (CLR) begin
      SYNCED     <= 1'b0;
      EXP_Q      <= '0;
      exp_rco    <= 1'b0;
      ERR        <= 1'b0;
      ERR_STICKY <= 1'b0;
      ERR_CNT    <= '0;
      CHK_CNT    <= '0;
    end else begin
      SYNCED <= (state_nxt != UNSYNC);
      ERR    <= cmp_c && mismatch_c;
      if (cmp_c && mismatch_c) begin
        ERR_STICKY <= 1'b1;
        if (ERR_CNT != {EW{1'b1}}) ERR_CNT <= ERR_CNT + EW'(1);
      end
      if (cmp_c && (CHK_CNT != {CW{1'b1}})) CHK_CNT <= CHK_CNT + CW'(1);
      if (state == UNSYNC) begin
        if (load_c) EXP_Q <= D;
        exp_rco <= 1'b0;
      end else begin
        EXP_Q   <= exp_nxt;
        exp_rco <= rco_nxt;
      end
    end
  end

endmodule

// File: tb/tb_counter_checker.sv
// Self-checking bench for counter_checker: table of vectors plus hand-written multi-cycle sequences,
// expectations queued at drive time and compared after the sampling edge.
module tb_counter_checker;

`ifdef COUNTER_CHECKER_RCO_CHECK_EN
  localparam logic RCO_EN = 1'b1;
`else
  localparam logic RCO_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET_L;
  logic [15:0] D;
  logic        ENB;
  logic [1:0]  MODO;
  logic [15:0] Q;
  logic        RCO;
  logic        CLR;
  logic        SYNCED;
  logic [15:0] EXP_Q;
  logic        ERR;
  logic        ERR_STICKY;
  logic [7:0]  ERR_CNT;
  logic [15:0] CHK_CNT;

  counter_checker dut (
    .CLK(CLK), .RESET_L(RESET_L), .D(D), .ENB(ENB), .MODO(MODO), .Q(Q), .RCO(RCO), .CLR(CLR),
    .SYNCED(SYNCED), .EXP_Q(EXP_Q), .ERR(ERR), .ERR_STICKY(ERR_STICKY),
    .ERR_CNT(ERR_CNT), .CHK_CNT(CHK_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        clr;
    logic        enb;
    logic [1:0]  modo;
    logic [15:0] d;
    logic [15:0] q;
    logic        rco;
    logic        synced;
    logic [15:0] expq;
    logic        err;
    logic        sticky;
    logic [7:0]  errcnt;
    logic [15:0] chkcnt;
  } vec_t;

  int   checks   = 0;
  int   failures = 0;
  vec_t sb[$];
  vec_t tbl[25];

  function automatic vec_t mk(logic clr, logic enb, logic [1:0] modo, logic [15:0] d,
                              logic [15:0] q, logic rco, logic synced, logic [15:0] expq,
                              logic err, logic sticky, logic [7:0] errcnt, logic [15:0] chkcnt);
    vec_t v;
    v.clr = clr; v.enb = enb; v.modo = modo; v.d = d; v.q = q; v.rco = rco;
    v.synced = synced; v.expq = expq; v.err = err; v.sticky = sticky;
    v.errcnt = errcnt; v.chkcnt = chkcnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input vec_t e);
    check({tag, ".SYNCED"},     32'(SYNCED),     32'(e.synced));
    check({tag, ".EXP_Q"},      32'(EXP_Q),      32'(e.expq));
    check({tag, ".ERR"},        32'(ERR),        32'(e.err));
    check({tag, ".ERR_STICKY"}, 32'(ERR_STICKY), 32'(e.sticky));
    check({tag, ".ERR_CNT"},    32'(ERR_CNT),    32'(e.errcnt));
    check({tag, ".CHK_CNT"},    32'(CHK_CNT),    32'(e.chkcnt));
  endtask

  // Drive one vector before an edge, queue its expectation, compare just after the edge
  task automatic drive_vec(input string tag, input vec_t v);
    vec_t e;
    @(negedge CLK);
    CLR = v.clr; ENB = v.enb; MODO = v.modo; D = v.d; Q = v.q; RCO = v.rco;
    sb.push_back(v);
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      check_outputs(tag, e);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t z;
    z = mk(0,0,2'b00,16'h0,16'h0,0, 0,16'h0,0,0,8'h0,16'h0);

    // Directed table: carry wrap, RCO-only mismatch, down-by-3 mismatch, in-CHECK reloads
    tbl[0]  = mk(1,0,2'b00,16'h0000,16'h0000,0, 0,16'h0000,0,0,8'd0,16'd0);
    tbl[1]  = mk(0,1,2'b11,16'hFFFF,16'h0000,0, 1,16'hFFFF,0,0,8'd0,16'd0);
    tbl[2]  = mk(0,1,2'b00,16'h0000,16'hFFFF,0, 1,16'h0000,0,0,8'd0,16'd1);
    tbl[3]  = mk(0,0,2'b00,16'h0000,16'h0000,1, 1,16'h0000,0,0,8'd0,16'd2);
    tbl[4]  = mk(1,0,2'b00,16'h0000,16'h0000,0, 0,16'h0000,0,0,8'd0,16'd0);
    tbl[5]  = mk(0,1,2'b11,16'hFFFF,16'h0000,0, 1,16'hFFFF,0,0,8'd0,16'd0);
    tbl[6]  = mk(0,1,2'b00,16'h0000,16'hFFFF,0, 1,16'h0000,0,0,8'd0,16'd1);
    tbl[7]  = mk(0,0,2'b00,16'h0000,16'h0000,0, 1,16'h0000,RCO_EN,RCO_EN,8'(RCO_EN),16'd2);
    tbl[8]  = mk(0,0,2'b00,16'h0000,16'h0000,0, 1,16'h0000,0,RCO_EN,8'(RCO_EN),16'd3);
    tbl[9]  = mk(1,0,2'b00,16'h0000,16'h0000,0, 0,16'h0000,0,0,8'd0,16'd0);
    tbl[10] = mk(0,1,2'b11,16'h0001,16'h7777,0, 1,16'h0001,0,0,8'd0,16'd0);
    tbl[11] = mk(0,1,2'b10,16'h0000,16'h0001,0, 1,16'hFFFE,0,0,8'd0,16'd1);
    tbl[12] = mk(0,1,2'b10,16'h0000,16'hFFFF,1, 1,16'hFFFB,1,1,8'd1,16'd2);
    tbl[13] = mk(0,0,2'b10,16'h0000,16'hFFFB,0, 1,16'hFFFB,0,1,8'd1,16'd3);
    tbl[14] = mk(0,1,2'b11,16'h0002,16'hFFFB,0, 1,16'h0002,0,1,8'd1,16'd4);
    tbl[15] = mk(0,1,2'b01,16'h0000,16'h0002,0, 1,16'h0001,0,1,8'd1,16'd5);
    tbl[16] = mk(0,1,2'b01,16'h0000,16'h0001,0, 1,16'h0000,0,1,8'd1,16'd6);
    tbl[17] = mk(0,1,2'b01,16'h0000,16'h0000,0, 1,16'hFFFF,0,1,8'd1,16'd7);
    tbl[18] = mk(0,1,2'b10,16'h0000,16'hFFFF,1, 1,16'hFFFC,0,1,8'd1,16'd8);
    tbl[19] = mk(0,0,2'b00,16'h0000,16'hFFFC,0, 1,16'hFFFC,0,1,8'd1,16'd9);
    tbl[20] = mk(0,1,2'b11,16'h0003,16'hFFFC,0, 1,16'h0003,0,1,8'd1,16'd10);
    tbl[21] = mk(0,1,2'b10,16'h0000,16'h0003,0, 1,16'h0000,0,1,8'd1,16'd11);
    tbl[22] = mk(0,1,2'b11,16'h0002,16'h0000,0, 1,16'h0002,0,1,8'd1,16'd12);
    tbl[23] = mk(0,1,2'b10,16'h0000,16'h0002,0, 1,16'hFFFF,0,1,8'd1,16'd13);
    tbl[24] = mk(0,0,2'b00,16'h0000,16'hFFFF,1, 1,16'hFFFF,0,1,8'd1,16'd14);

    RESET_L = 1'b0; CLR = 1'b0; ENB = 1'b0; MODO = 2'b00; D = '0; Q = '0; RCO = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_outputs("reset", z);
    @(negedge CLK);
    RESET_L = 1'b1;

    for (int i = 0; i < 25; i++) drive_vec($sformatf("tbl%0d", i), tbl[i]);

    // No comparisons before the first load
    drive_vec("nosync_clr", mk(1,0,2'b00,16'h0,16'h0,0, 0,16'h0,0,0,8'd0,16'd0));
    for (int i = 0; i < 10; i++)
      drive_vec($sformatf("nosync%0d", i),
                mk(0,1,2'b00,16'($urandom),16'($urandom),1'($urandom), 0,16'h0,0,0,8'd0,16'd0));

    // Clean count-up after reset: 21 comparisons, never an error
    @(negedge CLK); RESET_L = 1'b0;
    @(negedge CLK); RESET_L = 1'b1;
    drive_vec("up_load", mk(0,1,2'b11,16'h0000,16'hABCD,0, 1,16'h0000,0,0,8'd0,16'd0));
    for (int i = 1; i <= 20; i++)
      drive_vec($sformatf("up%0d", i),
                mk(0,1,2'b00,16'h0,16'(i-1),0, 1,16'(i),0,0,8'd0,16'(i)));
    drive_vec("up_last", mk(0,0,2'b00,16'h0,16'd20,0, 1,16'd20,0,0,8'd0,16'd21));

    // Error counter saturation, then CLR beating a simultaneous load
    drive_vec("sat_clr", mk(1,0,2'b00,16'h0,16'h0,0, 0,16'h0,0,0,8'd0,16'd0));
    drive_vec("sat_load", mk(0,1,2'b11,16'h0000,16'h0,0, 1,16'h0,0,0,8'd0,16'd0));
    for (int n = 1; n <= 300; n++)
      drive_vec($sformatf("sat%0d", n),
                mk(0,0,2'b00,16'h0,16'h0001,0, 1,16'h0,1,1,8'((n > 255) ? 255 : n),16'(n)));
    drive_vec("sat_clrload", mk(1,1,2'b11,16'h5555,16'h0001,0, 0,16'h0,0,0,8'd0,16'd0));
    drive_vec("sat_unsync", mk(0,0,2'b00,16'h0,16'h0001,0, 0,16'h0,0,0,8'd0,16'd0));

    // Reset mid-CHECK with a mismatch pending
    drive_vec("rst_load", mk(0,1,2'b11,16'h1234,16'h0,0, 1,16'h1234,0,0,8'd0,16'd0));
    drive_vec("rst_armed", mk(0,0,2'b00,16'h0,16'h1234,0, 1,16'h1234,0,0,8'd0,16'd1));
    @(negedge CLK);
    Q = 16'h0000; ENB = 1'b0; RESET_L = 1'b0;
    #1;
    check_outputs("rst_async", z);
    @(negedge CLK);
    RESET_L = 1'b1;
    drive_vec("rst_post0", mk(0,0,2'b00,16'h0,16'h0,0, 0,16'h0,0,0,8'd0,16'd0));
    drive_vec("rst_post1", mk(0,0,2'b00,16'h0,16'h0,0, 0,16'h0,0,0,8'd0,16'd0));

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d left expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_checker.md
COUNTER_CHECKER -- requirements
Module: counter_checker

Interface
REQ-001 The module SHALL have ports: CLK, input, 1, sole clock, all state updates on its rising edge.
REQ-002 RESET_L, input, 1, SHALL be an asynchronous, active-low reset.
REQ-003 D, input, 16, parallel-load value driven to the counter under check.
REQ-004 ENB, input, 1, counter enable as driven to the counter under check.
REQ-005 MODO, input, 2, counter mode: 00 up by 1, 01 down by 1, 10 down by 3, 11 parallel load.
REQ-006 Q, input, 16, counter output being checked.
REQ-007 RCO, input, 1, counter ripple-carry output being checked.
REQ-008 CLR, input, 1, synchronous clear of checker state and statistics.
REQ-009 SYNCED, output, 1, reference model holds a valid expected value.
REQ-010 EXP_Q, output, 16, current expected counter value.
REQ-011 ERR, output, 1, single-cycle pulse on any mismatch.
REQ-012 ERR_STICKY, output, 1, set on first mismatch, held until reset or CLR.
REQ-013 ERR_CNT, output, 8, mismatch count, saturating at 8'hFF.
REQ-014 CHK_CNT, output, 16, comparisons performed, saturating at 16'hFFFF.

Function
REQ-015 The module SHALL sample D, ENB, MODO at each rising CLK edge, the same edge at which the counter under check samples them.
REQ-016 The reference model SHALL compute next EXP_Q from the sampled inputs and the current EXP_Q: ENB=0 hold; MODO=00 EXP_Q+1; 01 EXP_Q-1; 10 EXP_Q-3; 11 D; all arithmetic modulo 2^16.
REQ-017 Expected RCO SHALL be: 1 for MODO=00 from 16'hFFFF, 1 for MODO=01 from 16'h0000, 1 for MODO=10 from any value below 3, otherwise 0, and always 0 when ENB=0 or MODO=11.
REQ-018 FSM states SHALL be UNSYNC, ARMED, CHECK.
REQ-019 UNSYNC: no comparisons; ENB=1 and MODO=11 sampled SHALL load EXP_Q from D and move to ARMED.
REQ-020 ARMED: the model SHALL update per REQ-016; at the next edge, compare and move to CHECK.
REQ-021 CHECK: every edge SHALL compare Q (and RCO per Configuration) against the expectation computed at the previous edge, then update the model.
REQ-022 Comparison latency SHALL be exactly one cycle: inputs sampled at edge k are checked against Q at edge k+1.
REQ-023 A mismatch SHALL assert ERR for exactly the following cycle, set ERR_STICKY, increment ERR_CNT unless at 8'hFF.
REQ-024 Each comparison SHALL increment CHK_CNT unless at 16'hFFFF.
REQ-025 After a mismatch the model SHALL continue from its own expectation, not resynchronize to Q.
REQ-026 A parallel load in ARMED or CHECK SHALL reload EXP_Q from D without leaving the current state.
REQ-027 SYNCED SHALL be 1 in ARMED and CHECK, 0 in UNSYNC.
REQ-028 CLR=1 SHALL return to UNSYNC and zero EXP_Q, ERR, ERR_STICKY, ERR_CNT, CHK_CNT, with priority over a simultaneous load, comparison, or mismatch.

Reset
REQ-029 RESET_L=0 SHALL immediately force UNSYNC and drive SYNCED=0, EXP_Q=16'h0000, ERR=0, ERR_STICKY=0, ERR_CNT=8'h00, CHK_CNT=16'h0000.
REQ-030 Reset asserted mid-operation SHALL discard any pending comparison; no ERR pulse SHALL follow reset release.

Configuration
REQ-031 With macro COUNTER_CHECKER_RCO_CHECK_EN defined, a mismatch SHALL be Q differing from expected OR RCO differing from expected RCO.
REQ-032 Without COUNTER_CHECKER_RCO_CHECK_EN, RCO SHALL be ignored and only Q compared; port list unchanged.

Verification
REQ-033 Reset, load D=16'h0000 MODO=11, then MODO=00 for 20 cycles with correct counter -> SYNCED=1, CHK_CNT=21, ERR never asserted, ERR_CNT=0.
REQ-034 Load 16'hFFFF, MODO=00 one cycle, Q=0000, RCO=1 -> no ERR; same with RCO=0 -> ERR pulse only when COUNTER_CHECKER_RCO_CHECK_EN defined.
REQ-035 Load 16'h0001, MODO=10 -> expected 16'hFFFE with RCO=1; Q driven 16'hFFFF -> one ERR pulse, ERR_STICKY=1, ERR_CNT=1, next expectation 16'hFFFB.
REQ-036 Before any load, MODO=00 with arbitrary Q for 10 cycles -> SYNCED=0, CHK_CNT=0, ERR never asserted.
REQ-037 Force 300 consecutive mismatches -> ERR_CNT saturates at 8'hFF; CLR one cycle -> all statistics 0, state UNSYNC.
REQ-038 RESET_L low for 1 cycle in CHECK with a mismatch pending -> outputs at reset values, no ERR after release.
